fir_stim_gen: RTL and testbench
===============================

# fir_stim_gen

Synthesizable sample-stream source that drives the input port of the distributed-arithmetic low-pass FIR (`fir_distb_top.fir_lp_in`). It produces one of four deterministic test patterns (impulse, step, square, LFSR noise) at a programmable sample rate. It runs a start/busy/done sequence, so on-chip self-test and the bench can exercise the filter without a file-driven stimulus. It sits directly upstream of the FIR, in the same `sys_clk` domain.

## Interface
- `ODATA_WIDTH`, 8, sample width; equals the FIR input width (`IDATA_WIDTH`); legal range 4..16.
- `CNT_WIDTH`, 16, width of the sample-count and index fields.
- `DIV_WIDTH`, 8, width of the rate divider.
- `sys_clk` in 1: single clock; all logic is on the rising edge.
- `sys_rst` in 1: reset; synchronous, active-high.
- `start` in 1: request a run; sampled only in IDLE.
- `mode` in 2: pattern select. 0 impulse, 1 step, 2 square, 3 LFSR.
- `num_samples` in CNT_WIDTH: number of samples per run.
- `rate_div` in DIV_WIDTH: strobe period is rate_div+1 clocks.
- `amplitude` in ODATA_WIDTH: signed two's-complement pattern amplitude.
- `fir_lp_in` out ODATA_WIDTH: sample to the FIR; registered; holds its value between strobes.
- `sample_vld` out 1: one-cycle strobe; `fir_lp_in` carries a new sample in that cycle.
- `sample_idx` out CNT_WIDTH: 0-based index of the current sample.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`=1 when `num_samples`≠0.
  - IDLE→DONE on `start`=1 when `num_samples`=0; no samples are emitted.
  - RUN→DONE on the cycle after the last sample strobe.
  - DONE→IDLE unconditionally after one cycle.
- When `start` is accepted, the block latches `mode`, `num_samples`, `rate_div` and `amplitude`. Input changes during a run have no effect.
- `start` is ignored in RUN and DONE. It is not queued.
- Sample n (n = 0 .. num_samples-1), where A = latched amplitude:
  - impulse: A when n=0, else 0.
  - step: A for every n.
  - square: A when (n mod 16) < 8, else −A. −A saturates: when A is the most negative value, −A becomes the most positive value (e.g. 8'h80 → 8'h7F).
  - LFSR: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on every accepted start.
    - Feedback = s[15]^s[13]^s[12]^s[10]. Shift left and insert the feedback at bit 0.
    - The LFSR advances once per emitted sample, after that sample is taken.
    - Sample n = s[ODATA_WIDTH-1:0] after n advances. `amplitude` is ignored.
- The rate counter reloads to `rate_div` at each strobe and decrements every clock. The next strobe fires when it reaches 0.
- On entry to DONE, `fir_lp_in` is cleared to 0 and `sample_idx` is cleared to 0.

## Timing
- Reset values (all outputs): `fir_lp_in`=0, `sample_vld`=0, `sample_idx`=0, `busy`=0, `done`=0. FSM in IDLE, LFSR holds 16'hACE1.
- Reset is synchronous and overrides everything. Asserting it mid-run returns the block to IDLE on the next edge, with no `done` pulse.
- Let `start` be sampled high at edge k (in IDLE). Then:
  - `busy`=1, first `sample_vld`, and sample 0 all appear in cycle k+1.
  - Strobe j occurs in cycle k+1+j·(rate_div+1).
- The last strobe occurs in cycle L = k+1+(N−1)·(rate_div+1). Then `busy`=0 and `done`=1 in cycle L+1, and the FSM is back in IDLE in cycle L+2.
- The earliest new `start` is accepted at edge L+2 (the first IDLE cycle).
- For `num_samples`=0: `done`=1 in cycle k+1, `busy` stays 0, and there is no `sample_vld`.
- With `rate_div`=0, `sample_vld` is high continuously for N cycles.
- Maximum run length is 2^CNT_WIDTH−1 samples. `sample_idx` never wraps within a run.

## Test plan
- Impulse, A=8'h40, N=4, div=0, start at edge k:
  - `fir_lp_in` = 40,00,00,00 in cycles k+1..k+4, with `sample_vld` high throughout.
  - `done` pulse in cycle k+5, then `fir_lp_in`=0.
- Square, A=8'h80, N=20, div=2:
  - Strobes every 3 clocks.
  - Samples 0–7 = 8'h80, samples 8–15 = 8'h7F (saturated), samples 16–19 = 8'h80.
  - `sample_idx` tracks 0..19.
- LFSR, N=3, div=0:
  - Samples are 8'hE1, 8'hC3, then the next low byte of the LFSR state.
  - A second run repeats the identical sequence.
- `num_samples`=0:
  - `done` asserts in the cycle after start.
  - `busy` and `sample_vld` never assert.
- Step, A=8'h10, N=10, div=1; pulse `start` and change `mode` at sample 3:
  - The run is unaffected.
  - Exactly 10 strobes occur and exactly one `done`.
- Step, N=10; assert `sys_rst` after sample 5:
  - All outputs are at reset values on the next edge.
  - No `done` pulse.
  - A fresh start afterwards behaves normally.

Source files
------------

// File: rtl/fir_stim_gen_if.sv
// Control, status and sample-stream bundle between the FIR stimulus generator and its user.
// The generator owns the master side; the FIR/bench side uses the slave modport.
interface fir_stim_gen_if #(
    parameter int unsigned ODATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DIV_WIDTH   = 8
) ();
    logic                   start;
    logic [1:0]             mode;
    logic [CNT_WIDTH-1:0]   num_samples;
    logic [DIV_WIDTH-1:0]   rate_div;
    logic [ODATA_WIDTH-1:0] amplitude;
    logic [ODATA_WIDTH-1:0] fir_lp_in;
    logic                   sample_vld;
    logic [CNT_WIDTH-1:0]   sample_idx;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, mode, num_samples, rate_div, amplitude,
        output fir_lp_in, sample_vld, sample_idx, busy, done
    );

    modport slave (
        output start, mode, num_samples, rate_div, amplitude,
        input  fir_lp_in, sample_vld, sample_idx, busy, done
    );
endinterface

// File: rtl/fir_stim_gen.sv
// Deterministic sample-stream source for the DA low-pass FIR input: impulse, step,
// saturated square or LFSR noise, one sample every rate_div+1 clocks, start/busy/done sequenced.
module fir_stim_gen #(
    parameter int unsigned ODATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DIV_WIDTH   = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    fir_stim_gen_if.master bus
);
    localparam int unsigned             LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0]   LFSR_SEED  = 16'hACE1;
    localparam logic [ODATA_WIDTH-1:0]  DATA_MIN   = {1'b1, {(ODATA_WIDTH-1){1'b0}}};
    localparam logic [ODATA_WIDTH-1:0]  DATA_MAX   = ~DATA_MIN;
    localparam logic [1:0]              MODE_IMPULSE = 2'd0;
    localparam logic [1:0]              MODE_STEP    = 2'd1;
    localparam logic [1:0]              MODE_SQUARE  = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [ODATA_WIDTH-1:0] amp_q, amp_d;
    logic [DIV_WIDTH-1:0]   rate_q, rate_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [ODATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   emit;
    logic [1:0]             sel_mode;
    logic [ODATA_WIDTH-1:0] sel_amp;
    logic [ODATA_WIDTH-1:0] neg_amp;
    logic [CNT_WIDTH-1:0]   nxt_idx;
    logic [LFSR_WIDTH-1:0]  lfsr_nxt;

    // State register; reset overrides everything, including a run in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            num_q   <= '0;
            div_q   <= '0;
            amp_q   <= '0;
            rate_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            data_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            div_q   <= div_d;
            amp_q   <= amp_d;
            rate_q  <= rate_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath; the first sample is built from the live inputs on the start edge.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        num_d    = num_q;
        div_d    = div_q;
        amp_d    = amp_q;
        rate_d   = rate_q;
        lfsr_d   = lfsr_q;
        data_d   = data_q;
        idx_d    = idx_q;
        vld_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        emit     = 1'b0;
        sel_mode = mode_q;
        sel_amp  = amp_q;
        nxt_idx  = idx_q + CNT_WIDTH'(1);
        lfsr_nxt = {lfsr_q[LFSR_WIDTH-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    num_d  = bus.num_samples;
                    div_d  = bus.rate_div;
                    amp_d  = bus.amplitude;
                    if (bus.num_samples == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        data_d  = '0;
                        idx_d   = '0;
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        emit     = 1'b1;
                        rate_d   = bus.rate_div;
                        sel_mode = bus.mode;
                        sel_amp  = bus.amplitude;
                        nxt_idx  = '0;
                        lfsr_nxt = LFSR_SEED;
                    end
                end
            end
            RUN: begin
                if (vld_q && (idx_q == num_q - CNT_WIDTH'(1))) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    data_d  = '0;
                    idx_d   = '0;
                end else if (rate_q == '0) begin
                    emit   = 1'b1;
                    rate_d = div_q;
                end else begin
                    rate_d = rate_q - DIV_WIDTH'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Negation saturates so the most negative amplitude maps to the most positive code.
        neg_amp = (sel_amp == DATA_MIN) ? DATA_MAX : -sel_amp;

        if (emit) begin
            vld_d  = 1'b1;
            idx_d  = nxt_idx;
            lfsr_d = lfsr_nxt;
            unique case (sel_mode)
                MODE_IMPULSE: data_d = (nxt_idx == '0) ? sel_amp : '0;
                MODE_STEP:    data_d = sel_amp;
                MODE_SQUARE:  data_d = nxt_idx[3] ? neg_amp : sel_amp;
                default:      data_d = lfsr_nxt[ODATA_WIDTH-1:0];
            endcase
        end
    end

    assign bus.fir_lp_in  = data_q;
    assign bus.sample_vld = vld_q;
    assign bus.sample_idx = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench for fir_stim_gen: each run is captured cycle by cycle after the start edge
// and compared against hand-computed samples, strobe timing, busy window and done pulse.
module tb_fir_stim_gen;
    logic sys_clk;
    logic sys_rst;

    fir_stim_gen_if #(.ODATA_WIDTH(8), .CNT_WIDTH(16), .DIV_WIDTH(8)) bus ();

    fir_stim_gen #(.ODATA_WIDTH(8), .CNT_WIDTH(16), .DIV_WIDTH(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_data[$];
    int         got_idx[$];
    int         got_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] mode, input int n, input int div, input logic [7:0] amp);
        @(negedge sys_clk);
        bus.mode        = mode;
        bus.num_samples = 16'(n);
        bus.rate_div    = 8'(div);
        bus.amplitude   = amp;
        bus.start       = 1'b1;
        @(posedge sys_clk);
        #1 bus.start = 1'b0;
    endtask

    // Capture one run starting at cycle k+1 and compare against exp_q.
    task automatic run_check(input string tag, input int n, input int div, input int poke);
        int last;
        int done_exp;
        int busy_err;
        int n_done;
        int done_c;
        logic [7:0]  data_at_done;
        logic [15:0] idx_at_done;
        bit poked;
        last         = (n == 0) ? 0 : (n - 1) * (div + 1) + 1;
        done_exp     = (n == 0) ? 1 : last + 1;
        busy_err     = 0;
        n_done       = 0;
        done_c       = -1;
        data_at_done = 8'hAA;
        idx_at_done  = 16'hAAAA;
        poked        = 1'b0;
        got_data.delete();
        got_idx.delete();
        got_cyc.delete();
        for (int c = 1; c <= done_exp + 3; c++) begin
            @(negedge sys_clk);
            if (poked) bus.start = 1'b0;
            if (bus.busy !== ((n != 0) && (c <= last))) busy_err++;
            if (bus.sample_vld === 1'b1) begin
                got_data.push_back(bus.fir_lp_in);
                got_idx.push_back(int'(bus.sample_idx));
                got_cyc.push_back(c);
                if (!poked && poke >= 0 && int'(bus.sample_idx) == poke) begin
                    bus.start       = 1'b1;
                    bus.mode        = 2'd2;
                    bus.amplitude   = 8'h55;
                    bus.num_samples = 16'd3;
                    bus.rate_div    = 8'd0;
                    poked           = 1'b1;
                end
            end
            if (bus.done === 1'b1) begin
                n_done++;
                done_c       = c;
                data_at_done = bus.fir_lp_in;
                idx_at_done  = bus.sample_idx;
            end
        end
        bus.start = 1'b0;
        check_eq({tag, "_nstrobe"}, got_data.size(), n);
        for (int i = 0; i < got_data.size() && i < n; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_q[i]);
            check_eq($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
            check_eq($sformatf("%s_cyc%0d", tag, i), got_cyc[i], 1 + i * (div + 1));
        end
        check_eq({tag, "_busy_window"}, busy_err, 0);
        check_eq({tag, "_ndone"}, n_done, 1);
        check_eq({tag, "_done_cyc"}, done_c, done_exp);
        check_eq({tag, "_data_at_done"}, data_at_done, 8'h00);
        check_eq({tag, "_idx_at_done"}, idx_at_done, 16'h0000);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data"}, bus.fir_lp_in, 8'h00);
        check_eq({tag, "_vld"}, bus.sample_vld, 1'b0);
        check_eq({tag, "_idx"}, bus.sample_idx, 16'h0000);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_done"}, bus.done, 1'b0);
    endtask

    initial begin
        int found;
        int quiet_err;
        sys_rst         = 1'b1;
        bus.start       = 1'b0;
        bus.mode        = 2'd0;
        bus.num_samples = 16'd0;
        bus.rate_div    = 8'd0;
        bus.amplitude   = 8'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_idle_outputs("reset");
        sys_rst = 1'b0;

        // Impulse A=40, N=4, div=0.
        exp_q = '{8'h40, 8'h00, 8'h00, 8'h00};
        pulse_start(2'd0, 4, 0, 8'h40);
        run_check("impulse", 4, 0, -1);

        // Square A=80 (most negative), N=20, div=2: -A saturates to 7F.
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(((i % 16) < 8) ? 8'h80 : 8'h7F);
        pulse_start(2'd2, 20, 2, 8'h80);
        run_check("square", 20, 2, -1);

        // LFSR from seed ACE1: ACE1 -> 59C3 -> B387; amplitude ignored; second run identical.
        exp_q = '{8'hE1, 8'hC3, 8'h87};
        pulse_start(2'd3, 3, 0, 8'h12);
        run_check("lfsr1", 3, 0, -1);
        pulse_start(2'd3, 3, 0, 8'h34);
        run_check("lfsr2", 3, 0, -1);

        // Zero-length run: done only, no busy, no strobes.
        exp_q.delete();
        pulse_start(2'd1, 0, 0, 8'h10);
        run_check("zero", 0, 0, -1);

        // Step A=10, N=10, div=1; start and new settings poked during sample 3.
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h10);
        pulse_start(2'd1, 10, 1, 8'h10);
        run_check("step_poke", 10, 1, 3);

        // Reset mid-run after sample 5.
        pulse_start(2'd1, 10, 0, 8'h10);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge sys_clk);
            if (bus.sample_vld === 1'b1 && bus.sample_idx == 16'd5) found = 1;
        end
        check_eq("rst_reach_s5", found, 1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1 check_idle_outputs("rst_mid");
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        quiet_err = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sample_vld !== 1'b0) quiet_err++;
        end
        check_eq("rst_quiet", quiet_err, 0);

        // Fresh run after reset.
        exp_q = '{8'hF0, 8'hF0, 8'hF0};
        pulse_start(2'd1, 3, 1, 8'hF0);
        run_check("post_rst", 3, 1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
